// File: rtl/bnn_stream_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : bnn_stream_sequencer
// Purpose  : Load/compute sequencer for the BNN accelerator: streams both conv
//            kernels, the image and the FC weights, then reports the class.
//            Optional macro SEQ_PERF_CNT_EN adds the perf_cycles counter.
// Revision : 1.0 - initial release
// ============================================================================
module bnn_stream_sequencer #(
    parameter int KERNEL_BITS = 9,
    parameter int NUM_KERNELS = 2,
    parameter int IMG_PIXELS  = 784,
    parameter int FC_LEN      = 338,
    parameter int CNT_W       = 11
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       src_ready,
    input  logic       core_done,
    input  logic [3:0] classes_in,
    output logic       weight_en_0,
    output logic       weight_en_1,
    output logic       pix_valid,
    output logic       fc_ivalid,
    output logic       busy,
    output logic       done,
    output logic [3:0] classes_b,
    output logic       err_timeout
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [31:0] perf_cycles
`endif
);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_K0     = 3'd1;
    localparam logic [2:0] c_K1     = 3'd2;
    localparam logic [2:0] c_IMG    = 3'd3;
    localparam logic [2:0] c_FC     = 3'd4;
    localparam logic [2:0] c_WAIT   = 3'd5;
    localparam logic [2:0] c_REPORT = 3'd6;

    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_K_LAST   = CNT_W'(KERNEL_BITS - 1);
    localparam logic [CNT_W-1:0] c_IMG_LAST = CNT_W'(IMG_PIXELS - 1);
    localparam logic [CNT_W-1:0] c_FC_LAST  = CNT_W'(FC_LEN - 1);

    logic [2:0]       r_state;
    logic [2:0]       w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_last;
    logic             w_streaming;
    logic             w_adv;
    logic             w_timeout;
    logic             w_en0_d;
    logic             w_en1_d;
    logic             w_pix_d;
    logic             w_fc_d;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_last = '0;
        case (r_state)
            c_K0, c_K1: w_last = c_K_LAST;
            c_IMG:      w_last = c_IMG_LAST;
            c_FC:       w_last = c_FC_LAST;
            default:    w_last = '0;
        endcase
    end

    assign w_streaming = (r_state == c_K0) || (r_state == c_K1) ||
                         (r_state == c_IMG) || (r_state == c_FC);
    assign w_adv       = w_streaming && src_ready && (r_cnt == w_last);
    // Watchdog reuses the element counter: 2**CNT_W cycles spent in WAIT.
    assign w_timeout   = (r_state == c_WAIT) && !core_done && (r_cnt == '1);

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:   if (start) w_state_next = c_K0;
            c_K0:     if (w_adv) w_state_next = (NUM_KERNELS > 1) ? c_K1 : c_IMG;
            c_K1:     if (w_adv) w_state_next = c_IMG;
            c_IMG:    if (w_adv) w_state_next = c_FC;
            c_FC:     if (w_adv) w_state_next = c_WAIT;
            c_WAIT:   if (core_done || w_timeout) w_state_next = c_REPORT;
            c_REPORT: w_state_next = c_IDLE;
            default:  w_state_next = c_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        w_en0_d = (r_state == c_K0)  && src_ready;
        w_en1_d = (r_state == c_K1)  && src_ready;
        w_pix_d = (r_state == c_IMG) && src_ready;
        w_fc_d  = (r_state == c_FC)  && src_ready;
        busy    = (r_state != c_IDLE);
        done    = (r_state == c_REPORT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            weight_en_0 <= 1'b0;
            weight_en_1 <= 1'b0;
            pix_valid   <= 1'b0;
            fc_ivalid   <= 1'b0;
            classes_b   <= 4'd0;
            err_timeout <= 1'b0;
        end else begin
            weight_en_0 <= w_en0_d;
            weight_en_1 <= w_en1_d;
            pix_valid   <= w_pix_d;
            fc_ivalid   <= w_fc_d;

            if (w_streaming) begin
                if (src_ready) begin
                    r_cnt <= w_adv ? '0 : r_cnt + c_CNT_ONE;
                end
            end else if (r_state == c_WAIT) begin
                r_cnt <= (core_done || w_timeout) ? '0 : r_cnt + c_CNT_ONE;
            end else begin
                r_cnt <= '0;
            end

            if ((r_state == c_WAIT) && core_done) begin
                classes_b <= classes_in;
            end

            if ((r_state == c_IDLE) && start) begin
                err_timeout <= 1'b0;
            end else if (w_timeout) begin
                err_timeout <= 1'b1;
            end
        end
    end

`ifdef SEQ_PERF_CNT_EN
    logic [31:0] r_run;

    // r_run holds (busy cycles so far - 1); the REPORT cycle completes the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_run       <= 32'd0;
            perf_cycles <= 32'd0;
        end else begin
            if (r_state == c_IDLE) begin
                r_run <= 32'd0;
            end else if (r_run != 32'hFFFF_FFFF) begin
                r_run <= r_run + 32'd1;
            end
            if (r_state == c_REPORT) begin
                perf_cycles <= (r_run == 32'hFFFF_FFFF) ? r_run : r_run + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_bnn_stream_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bnn_stream_sequencer
// Purpose  : Directed, table-driven self-checking bench for the sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bnn_stream_sequencer;

    localparam int KB  = 9;
    localparam int IMG = 784;
    localparam int FC  = 338;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       src_ready;
    logic       core_done;
    logic [3:0] classes_in;
    logic       weight_en_0;
    logic       weight_en_1;
    logic       pix_valid;
    logic       fc_ivalid;
    logic       busy;
    logic       done;
    logic [3:0] classes_b;
    logic       err_timeout;
`ifdef SEQ_PERF_CNT_EN
    logic [31:0] perf_cycles;
`endif

    bnn_stream_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .src_ready   (src_ready),
        .core_done   (core_done),
        .classes_in  (classes_in),
        .weight_en_0 (weight_en_0),
        .weight_en_1 (weight_en_1),
        .pix_valid   (pix_valid),
        .fc_ivalid   (fc_ivalid),
        .busy        (busy),
        .done        (done),
        .classes_b   (classes_b),
        .err_timeout (err_timeout)
`ifdef SEQ_PERF_CNT_EN
        ,
        .perf_cycles (perf_cycles)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor, sampled mid-cycle
    int n_k0 = 0, n_k1 = 0, n_pix = 0, n_fc = 0, n_done = 0, n_ovl = 0;
    int k0_first = 0, pix_first = 0, last_pix = 0, last_fc = 0, last_core = 0;
    int busy_run = 0;
    bit k0_armed = 1'b1, pix_armed = 1'b0, busy_prev = 1'b0;

    always @(negedge clk) begin
        if (!busy) k0_armed = 1'b1;
        if (weight_en_0) begin
            n_k0++;
            if (k0_armed) begin k0_first = cyc; k0_armed = 1'b0; end
        end
        if (weight_en_1) begin n_k1++; pix_armed = 1'b1; end
        if (pix_valid) begin
            n_pix++;
            last_pix = cyc;
            if (pix_armed) begin pix_first = cyc; pix_armed = 1'b0; end
        end
        if (fc_ivalid) begin n_fc++; last_fc = cyc; end
        if (done) n_done++;
        if (core_done) last_core = cyc;
        if (32'(weight_en_0) + 32'(weight_en_1) + 32'(pix_valid) + 32'(fc_ivalid) > 1) n_ovl++;
        if (busy && !busy_prev) busy_run = 1;
        else if (busy) busy_run++;
        busy_prev = busy;
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        bit         stall;
        bit         spur;
        logic [3:0] cls;
        int         delay;
        logic [3:0] exp_cls;
        bit         exp_to;
    } vec_t;

    vec_t vecs[5];

    task automatic run_vec(input vec_t v);
        int b_k0, b_k1, b_pix, b_fc, b_done, b_ovl, done_cyc, span;
        bit ok;
        b_k0 = n_k0; b_k1 = n_k1; b_pix = n_pix; b_fc = n_fc;
        b_done = n_done; b_ovl = n_ovl;
        done_cyc = 0;
        @(posedge clk); #1;
        start = 1'b1; src_ready = 1'b1; classes_in = v.cls;
        @(posedge clk); #1;
        start = 1'b0;
        chk("err_timeout_cleared_by_start", 32'(err_timeout), 0);
        ok = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            if (n_fc - b_fc >= FC) begin ok = 1'b1; break; end
            src_ready  = v.stall ? !src_ready : 1'b1;
            start      = v.spur && (n_k1 - b_k1 == 3);
            core_done  = v.spur && (n_fc - b_fc == 100);
            classes_in = core_done ? 4'd9 : v.cls;
            @(posedge clk); #1;
        end
        start = 1'b0; core_done = 1'b0;
        chk("stream_complete", 32'(ok), 1);
        if (v.delay >= 0) begin
            repeat (v.delay) begin @(posedge clk); #1; end
            classes_in = v.cls; core_done = 1'b1;
            @(posedge clk); #1;
            core_done = 1'b0; classes_in = ~v.cls;
        end
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done) begin ok = 1'b1; done_cyc = cyc; break; end
        end
        chk("done_seen", 32'(ok), 1);
        chk("busy_during_done", 32'(busy), 1);
        chk("classes_b", 32'(classes_b), 32'(v.exp_cls));
        chk("err_timeout", 32'(err_timeout), 32'(v.exp_to));
        if (v.delay >= 0) chk("done_after_core_done", done_cyc - last_core, 1);
        else              chk("timeout_wait_cycles", done_cyc - last_fc, 2048);
        @(negedge clk);
        chk("busy_after_done", 32'(busy), 0);
        chk("done_one_cycle", 32'(done), 0);
        chk("err_timeout_sticky", 32'(err_timeout), 32'(v.exp_to));
        @(posedge clk); #1;
        chk("k0_strobes", n_k0 - b_k0, KB);
        chk("k1_strobes", n_k1 - b_k1, KB);
        chk("pix_strobes", n_pix - b_pix, IMG);
        chk("fc_strobes", n_fc - b_fc, FC);
        chk("strobe_overlap", n_ovl - b_ovl, 0);
        chk("done_pulses", n_done - b_done, 1);
        if (!v.stall) begin
            chk("contiguous_stream_span", last_fc - k0_first + 1, KB + KB + IMG + FC);
        end else begin
            span = last_pix - pix_first + 1;
            chk("stalled_img_span_1568pm1", 32'(span >= 1567 - 1 && span <= 1568 + 1), 1);
        end
`ifdef SEQ_PERF_CNT_EN
        chk("perf_cycles", int'(perf_cycles), busy_run);
`endif
    endtask

    initial begin
        vecs[0] = '{stall: 1'b0, spur: 1'b0, cls: 4'd7,  delay: 5,  exp_cls: 4'd7,  exp_to: 1'b0};
        vecs[1] = '{stall: 1'b1, spur: 1'b0, cls: 4'd3,  delay: 0,  exp_cls: 4'd3,  exp_to: 1'b0};
        vecs[2] = '{stall: 1'b0, spur: 1'b1, cls: 4'd5,  delay: 3,  exp_cls: 4'd5,  exp_to: 1'b0};
        vecs[3] = '{stall: 1'b0, spur: 1'b0, cls: 4'd4,  delay: -1, exp_cls: 4'd5,  exp_to: 1'b1};
        vecs[4] = '{stall: 1'b0, spur: 1'b0, cls: 4'd12, delay: 1,  exp_cls: 4'd12, exp_to: 1'b0};

        rst = 1'b1; start = 1'b0; src_ready = 1'b0; core_done = 1'b0; classes_in = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_strobes", 32'({weight_en_0, weight_en_1, pix_valid, fc_ivalid}), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_classes_b", 32'(classes_b), 0);
        chk("reset_err_timeout", 32'(err_timeout), 0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Reset in the middle of the image stream, then a full replay
        begin
            int b_pix;
            bit ok;
            b_pix = n_pix;
            ok = 1'b0;
            @(posedge clk); #1;
            start = 1'b1; src_ready = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            for (int i = 0; i < 2000; i++) begin
                if (n_pix - b_pix >= 400) begin ok = 1'b1; break; end
                @(posedge clk); #1;
            end
            chk("reached_pixel_400", 32'(ok), 1);
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            @(negedge clk);
            chk("midrst_strobes", 32'({weight_en_0, weight_en_1, pix_valid, fc_ivalid}), 0);
            chk("midrst_busy", 32'(busy), 0);
            chk("midrst_classes_b", 32'(classes_b), 0);
            chk("midrst_err_timeout", 32'(err_timeout), 0);
        end
        run_vec(vecs[0]);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
